// File: rtl/cordic_alu_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_alu_pkg
//  Description : Opcode encodings and saturation-constant helpers shared by
//                the CORDIC add/subtract pipeline, its interface and bench.
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic_alu_pkg;

   localparam int OP_WIDTH = 3;

   localparam logic [OP_WIDTH-1:0] OP_ADD     = 3'd0;
   localparam logic [OP_WIDTH-1:0] OP_SUB     = 3'd1;
   localparam logic [OP_WIDTH-1:0] OP_ADD_SAT = 3'd2;
   localparam logic [OP_WIDTH-1:0] OP_SUB_SAT = 3'd3;
   localparam logic [OP_WIDTH-1:0] OP_ADD_SHR = 3'd4;
   localparam logic [OP_WIDTH-1:0] OP_SUB_SHR = 3'd5;

   // Widest word the saturation helpers can describe; callers truncate.
   localparam int SAT_MAX_WIDTH = 64;

   // Largest positive two's-complement value of the given width (0111...1).
   function automatic logic [SAT_MAX_WIDTH-1:0] sat_max(input int width);
      logic [SAT_MAX_WIDTH-1:0] one;
      one = {{(SAT_MAX_WIDTH-1){1'b0}}, 1'b1};
      return (one << (width - 1)) - one;
   endfunction

   // Most negative two's-complement value of the given width (100...0).
   function automatic logic [SAT_MAX_WIDTH-1:0] sat_min(input int width);
      logic [SAT_MAX_WIDTH-1:0] one;
      one = {{(SAT_MAX_WIDTH-1){1'b0}}, 1'b1};
      return one << (width - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_alu_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_alu_pipe_if
//  Description : Request/response handshake bundle of the CORDIC add/sub
//                pipeline. master = producer/consumer side, slave = the unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cordic_alu_pipe_if
   import cordic_alu_pkg::*;
#(
   parameter int WORD_LENGTH = 16,
   parameter int SHIFT_WIDTH = $clog2(WORD_LENGTH)
);

   logic                   in_valid;
   logic                   in_ready;
   logic [OP_WIDTH-1:0]    op;
   logic [WORD_LENGTH-1:0] A;
   logic [WORD_LENGTH-1:0] B;
   logic [SHIFT_WIDTH-1:0] shift;
   logic                   out_valid;
   logic                   out_ready;
   logic [WORD_LENGTH-1:0] result;
   logic                   overflow;
   logic                   zero;
   logic                   negative;

   modport master (
      output in_valid, op, A, B, shift, out_ready,
      input  in_ready, out_valid, result, overflow, zero, negative
   );

   modport slave (
      input  in_valid, op, A, B, shift, out_ready,
      output in_ready, out_valid, result, overflow, zero, negative
   );

endinterface
`default_nettype wire

// File: rtl/cordic_alu_pipe_arith_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : arith_shifter
//  Description : Combinational sign-filling barrel shifter (data >>> shift)
//                placed in front of the first pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module arith_shifter #(
   parameter int WORD_LENGTH = 16,
   parameter int SHIFT_WIDTH = $clog2(WORD_LENGTH)
) (
   input  wire logic [WORD_LENGTH-1:0] i_data,
   input  wire logic [SHIFT_WIDTH-1:0] i_shift,
   output logic      [WORD_LENGTH-1:0] o_data
);

   // Arithmetic right shift: vacated high bits copy the sign bit.
   always_comb begin
      o_data = $signed(i_data) >>> i_shift;
   end

endmodule
`default_nettype wire

// File: rtl/cordic_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_alu_pipe
//  Description : Two-stage signed add/sub unit for one CORDIC channel with
//                optional B>>>shift, saturation, status flags and a
//                valid/ready handshake sustaining one op per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_alu_pipe
   import cordic_alu_pkg::*;
#(
   parameter int WORD_LENGTH = 16,
   parameter int SHIFT_WIDTH = $clog2(WORD_LENGTH)
) (
   input wire logic          clk,
   input wire logic          rst_n,
   cordic_alu_pipe_if.slave  bus
);

   localparam logic [WORD_LENGTH-1:0] c_sat_max = WORD_LENGTH'(sat_max(WORD_LENGTH));
   localparam logic [WORD_LENGTH-1:0] c_sat_min = WORD_LENGTH'(sat_min(WORD_LENGTH));

   // Stage 1 registers: opcode, A and the prepared (shifted/inverted) B.
   logic                   s1_valid_q, s1_valid_d;
   logic [OP_WIDTH-1:0]    op_q, op_d;
   logic [WORD_LENGTH-1:0] a_q, a_d;
   logic [WORD_LENGTH-1:0] b_q, b_d;

   // Stage 2 registers: final result and flags.
   logic                   s2_valid_q, s2_valid_d;
   logic [WORD_LENGTH-1:0] result_q, result_d;
   logic                   overflow_q, overflow_d;
   logic                   zero_q, zero_d;
   logic                   negative_q, negative_d;

   logic                   w_s1_adv;
   logic                   w_s2_adv;
   logic [WORD_LENGTH-1:0] w_b_shifted;
   logic [WORD_LENGTH-1:0] w_b_operand;
   logic                   w_s1_is_sub;
   logic                   w_cin;
   logic [WORD_LENGTH:0]   w_sum_ext;
   logic                   w_raw_ovf;
   logic                   w_is_sat;
   logic                   w_reserved;
   logic [WORD_LENGTH-1:0] w_final;

   arith_shifter #(
      .WORD_LENGTH (WORD_LENGTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
   ) u_arith_shifter (
      .i_data  (bus.B),
      .i_shift (bus.shift),
      .o_data  (w_b_shifted)
   );

   // Handshake: a stage moves when it is empty or its successor moves.
   always_comb begin
      w_s2_adv     = ~s2_valid_q | bus.out_ready;
      w_s1_adv     = ~s1_valid_q | w_s2_adv;
      bus.in_ready = w_s1_adv;
   end

   // Operand preparation ahead of S1: select shifted B, invert it for subtracts
   // (the +1 carry is re-derived from the registered opcode in S2).
   always_comb begin
      w_s1_is_sub = (bus.op == OP_SUB) || (bus.op == OP_SUB_SAT) || (bus.op == OP_SUB_SHR);
      w_b_operand = ((bus.op == OP_ADD_SHR) || (bus.op == OP_SUB_SHR)) ? w_b_shifted : bus.B;
      if (w_s1_is_sub) begin
         w_b_operand = ~w_b_operand;
      end
   end

   // S2 arithmetic: sign-extended adder, overflow, saturation and reserved ops.
   always_comb begin
      w_cin      = (op_q == OP_SUB) || (op_q == OP_SUB_SAT) || (op_q == OP_SUB_SHR);
      w_is_sat   = (op_q == OP_ADD_SAT) || (op_q == OP_SUB_SAT);
      w_reserved = (op_q > OP_SUB_SHR);
      w_sum_ext  = {a_q[WORD_LENGTH-1], a_q} + {b_q[WORD_LENGTH-1], b_q}
                 + {{WORD_LENGTH{1'b0}}, w_cin};
      // Extension bit and sign bit disagree exactly when both adder operands
      // share a sign and the wrapped sum's sign differs from it.
      w_raw_ovf  = w_sum_ext[WORD_LENGTH] ^ w_sum_ext[WORD_LENGTH-1];
      w_final    = w_sum_ext[WORD_LENGTH-1:0];
      if (w_reserved) begin
         w_final   = '0;
         w_raw_ovf = 1'b0;
      end else if (w_is_sat && w_raw_ovf) begin
         w_final = a_q[WORD_LENGTH-1] ? c_sat_min : c_sat_max;
      end
   end

   // Next-state for both stages; data only loads when the stage advances.
   always_comb begin
      s1_valid_d = s1_valid_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      s2_valid_d = s2_valid_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      zero_d     = zero_q;
      negative_d = negative_q;

      if (w_s1_adv) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            op_d = bus.op;
            a_d  = bus.A;
            b_d  = w_b_operand;
         end
      end

      if (w_s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            result_d   = w_final;
            overflow_d = w_raw_ovf;
            zero_d     = (w_final == '0);
            negative_d = w_final[WORD_LENGTH-1];
         end
      end
   end

   // Pipeline registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         s2_valid_q <= 1'b0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
         negative_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         s2_valid_q <= s2_valid_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
         zero_q     <= zero_d;
         negative_q <= negative_d;
      end
   end

   // Outputs come straight from S2 registers.
   always_comb begin
      bus.out_valid = s2_valid_q;
      bus.result    = result_q;
      bus.overflow  = overflow_q;
      bus.zero      = zero_q;
      bus.negative  = negative_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_cordic_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_alu_pipe
//  Description : Directed self-checking bench for cordic_alu_pipe
//                (WORD_LENGTH=16) with hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_alu_pipe;
   import cordic_alu_pkg::*;

   logic clk;
   logic rst_n;
   int   n_cmp  = 0;
   int   n_fail = 0;

   cordic_alu_pipe_if #(.WORD_LENGTH(16), .SHIFT_WIDTH(4)) bus ();

   cordic_alu_pipe #(
      .WORD_LENGTH (16),
      .SHIFT_WIDTH (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Step to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] s);
      bus.in_valid = v;
      bus.op       = o;
      bus.A        = a;
      bus.B        = b;
      bus.shift    = s;
   endtask

   // One op through an empty pipe with out_ready=1: accepted on the first
   // edge, result visible after the second edge.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] s,
                         input logic [15:0] e_res, input logic e_ovf,
                         input logic e_zero, input logic e_neg);
      drive(1'b1, o, a, b, s);
      check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
      tick();
      drive(1'b0, 3'd0, 16'h0, 16'h0, 4'd0);
      check({tag, ".early_valid"}, 32'(bus.out_valid), 32'd0);
      tick();
      check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ".result"},    32'(bus.result),    32'(e_res));
      check({tag, ".overflow"},  32'(bus.overflow),  32'(e_ovf));
      check({tag, ".zero"},      32'(bus.zero),      32'(e_zero));
      check({tag, ".negative"},  32'(bus.negative),  32'(e_neg));
      tick();
      check({tag, ".drained"},   32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      // Reset with a request offered: it must not be accepted.
      rst_n         = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b1, OP_ADD, 16'h1111, 16'h2222, 4'd0);
      tick();
      tick();
      check("rst.out_valid", 32'(bus.out_valid), 32'd0);
      check("rst.result",    32'(bus.result),    32'd0);
      check("rst.overflow",  32'(bus.overflow),  32'd0);
      check("rst.zero",      32'(bus.zero),      32'd0);
      check("rst.negative",  32'(bus.negative),  32'd0);
      check("rst.in_ready",  32'(bus.in_ready),  32'd1);
      rst_n = 1'b1;
      drive(1'b0, 3'd0, 16'h0, 16'h0, 4'd0);
      tick();
      tick();
      check("rst.no_ghost", 32'(bus.out_valid), 32'd0);

      // Directed vectors.
      run_op("add_ovf",   OP_ADD,     16'h7FFF, 16'h0001, 4'd0,  16'h8000, 1'b1, 1'b0, 1'b1);
      run_op("addsat",    OP_ADD_SAT, 16'h7FFF, 16'h0001, 4'd0,  16'h7FFF, 1'b1, 1'b0, 1'b0);
      run_op("subsat",    OP_SUB_SAT, 16'h8000, 16'h0001, 4'd0,  16'h8000, 1'b1, 1'b0, 1'b1);
      run_op("subshr",    OP_SUB_SHR, 16'h0100, 16'h8000, 4'd3,  16'h1100, 1'b0, 1'b0, 1'b0);
      run_op("addshr15",  OP_ADD_SHR, 16'h0000, 16'hFFFF, 4'd15, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      run_op("addshr0",   OP_ADD_SHR, 16'h0010, 16'h0020, 4'd0,  16'h0030, 1'b0, 1'b0, 1'b0);
      run_op("sub_zero",  OP_SUB,     16'h0005, 16'h0005, 4'd0,  16'h0000, 1'b0, 1'b1, 1'b0);
      run_op("sub_neg",   OP_SUB,     16'h0003, 16'h0005, 4'd0,  16'hFFFE, 1'b0, 1'b0, 1'b1);
      run_op("sub_wrap",  OP_SUB,     16'h0000, 16'h8000, 4'd0,  16'h8000, 1'b1, 1'b0, 1'b1);
      run_op("subsat_p",  OP_SUB_SAT, 16'h0000, 16'h8000, 4'd0,  16'h7FFF, 1'b1, 1'b0, 1'b0);
      run_op("rsvd7",     3'd7,       16'h1234, 16'h5678, 4'd2,  16'h0000, 1'b0, 1'b1, 1'b0);
      run_op("rsvd6",     3'd6,       16'h7FFF, 16'h0001, 4'd0,  16'h0000, 1'b0, 1'b1, 1'b0);

      // Back-pressure: three back-to-back ADDs with out_ready low.
      bus.out_ready = 1'b0;
      drive(1'b1, OP_ADD, 16'h0000, 16'h0001, 4'd0);
      check("bp.rdy1", 32'(bus.in_ready), 32'd1);
      tick();
      drive(1'b1, OP_ADD, 16'h0001, 16'h0001, 4'd0);
      check("bp.rdy2", 32'(bus.in_ready), 32'd1);
      tick();
      drive(1'b1, OP_ADD, 16'h0001, 16'h0002, 4'd0);
      check("bp.full_rdy", 32'(bus.in_ready),  32'd0);
      check("bp.valid",    32'(bus.out_valid), 32'd1);
      check("bp.res_a",    32'(bus.result),    32'd1);
      tick();
      check("bp.hold_res", 32'(bus.result),    32'd1);
      check("bp.hold_rdy", 32'(bus.in_ready),  32'd0);
      bus.out_ready = 1'b1;
      #1;
      check("bp.rdy_comb", 32'(bus.in_ready),  32'd1);
      tick();
      drive(1'b0, 3'd0, 16'h0, 16'h0, 4'd0);
      check("bp.v2",   32'(bus.out_valid), 32'd1);
      check("bp.res2", 32'(bus.result),    32'd2);
      tick();
      check("bp.v3",   32'(bus.out_valid), 32'd1);
      check("bp.res3", 32'(bus.result),    32'd3);
      tick();
      check("bp.empty", 32'(bus.out_valid), 32'd0);

      // Reset with two ops in flight and the consumer stalled.
      bus.out_ready = 1'b0;
      drive(1'b1, OP_ADD, 16'h0010, 16'h0001, 4'd0);
      tick();
      drive(1'b1, OP_ADD, 16'h0020, 16'h0001, 4'd0);
      tick();
      drive(1'b0, 3'd0, 16'h0, 16'h0, 4'd0);
      check("mid.pre_valid", 32'(bus.out_valid), 32'd1);
      check("mid.pre_res",   32'(bus.result),    32'h11);
      rst_n = 1'b0;
      tick();
      check("mid.out_valid", 32'(bus.out_valid), 32'd0);
      check("mid.result",    32'(bus.result),    32'd0);
      check("mid.overflow",  32'(bus.overflow),  32'd0);
      check("mid.zero",      32'(bus.zero),      32'd0);
      check("mid.negative",  32'(bus.negative),  32'd0);
      check("mid.in_ready",  32'(bus.in_ready),  32'd1);
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("mid.discarded", 32'(bus.out_valid), 32'd0);
      end

      // Recovery after reset.
      run_op("post_rst", OP_ADD, 16'h0002, 16'h0003, 4'd0, 16'h0005, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
